// File: rtl/bch_pkg.sv
// Shared types and helpers for the BCH test-chain sequencer.
package bch_pkg;

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StEncode   = 3'd1,
      StNoise    = 3'd2,
      StErrgen   = 3'd3,
      StDecode   = 3'd4,
      StFinished = 3'd5,
      StFault    = 3'd6
   } seq_state_t;

   localparam logic [3:0] STAGE_ENC   = 4'b0001;
   localparam logic [3:0] STAGE_NOISE = 4'b0010;
   localparam logic [3:0] STAGE_ERR   = 4'b0100;
   localparam logic [3:0] STAGE_DEC   = 4'b1000;

   localparam int unsigned CODE_LEN = 14;

   // First enabled stage strictly after cur in chain order; StIdle means "from the top".
   function automatic seq_state_t next_stage(input logic [3:0] mask, input seq_state_t cur);
      seq_state_t nxt;
      nxt = StFinished;
      for (int i = 3; i >= 0; i--) begin
         if (mask[i] && ((i + 1) > int'(cur))) nxt = seq_state_t'(3'(i + 1));
      end
      return nxt;
   endfunction

   function automatic logic [3:0] stage_mask(input seq_state_t s);
      logic [3:0] m;
      m = 4'b0000;
      case (s)
         StEncode: m = STAGE_ENC;
         StNoise:  m = STAGE_NOISE;
         StErrgen: m = STAGE_ERR;
         StDecode: m = STAGE_DEC;
         default:  m = 4'b0000;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/bch_seq_watchdog.sv
// Per-stage cycle counter; expired flags the last cycle a stage may wait for its done.
module bch_seq_watchdog #(
   parameter int unsigned W = 16
) (
   input  logic clk,
   input  logic rstn,
   input  logic run,
   input  logic restart,
   output logic expired
);

   localparam logic [W-1:0] LAST = {{(W-1){1'b1}}, 1'b0};

   logic [W-1:0] cnt_q;

   // The restart cycle counts as cycle 0, so the register holds k during cycle k afterwards.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q <= '0;
      end else if (!run) begin
         cnt_q <= '0;
      end else if (restart) begin
         cnt_q <= W'(1);
      end else begin
         cnt_q <= cnt_q + W'(1);
      end
   end

   assign expired = run && !restart && (cnt_q == LAST);

endmodule

// File: rtl/bch_stage_sequencer.sv
// Run-level start/done sequencer for encode -> noise -> error injection -> decode.
// Optional per-stage watchdog with FAULT state when BCH_SEQ_TIMEOUT_EN is defined.
module bch_stage_sequencer
   import bch_pkg::*;
#(
   parameter int unsigned MAX_ERRORS = 4,
   parameter int unsigned TIMEOUT_W  = 16
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       start,
   input  logic       abort,
   input  logic       cfg_enc_en,
   input  logic       cfg_noise_en,
   input  logic       cfg_err_en,
   input  logic [7:0] cfg_num_err,
   output logic       enc_start,
   output logic       noise_start,
   output logic       err_start,
   output logic       dec_start,
   input  logic       enc_done,
   input  logic       noise_done,
   input  logic       err_done,
   input  logic       dec_done,
   output logic [2:0] err_count,
   output logic       busy,
   output logic       run_done,
   output logic       fault,
   output logic [2:0] state_o
);

   seq_state_t state_q;
   seq_state_t start_next;
   seq_state_t adv_next;
   logic [3:0] mask_q;
   logic [3:0] pulse_q;
   logic [3:0] start_mask;
   logic [3:0] done_vec;
   logic [2:0] err_count_q;
   logic [2:0] num_clamped;
   logic       busy_q;
   logic       run_done_q;
   logic       in_stage;
   logic       first_cycle;
   logic       stage_done;

   always_comb begin
      // Decode rides on the encode enable; zero requested errors skips injection.
      start_mask  = {cfg_enc_en, cfg_err_en && (cfg_num_err != 8'd0), cfg_noise_en, cfg_enc_en};
      start_next  = next_stage(start_mask, StIdle);
      adv_next    = next_stage(mask_q, state_q);
      done_vec    = {dec_done, err_done, noise_done, enc_done};
      in_stage    = (stage_mask(state_q) != 4'b0000);
      first_cycle = |pulse_q;
      stage_done  = in_stage && !first_cycle && |(done_vec & stage_mask(state_q));
      num_clamped = (32'(cfg_num_err) > MAX_ERRORS) ? 3'(MAX_ERRORS) : cfg_num_err[2:0];
   end

`ifdef BCH_SEQ_TIMEOUT_EN
   logic       wd_expired;
   logic       fault_q;
   seq_state_t fault_stage_q;

   bch_seq_watchdog #(
      .W(TIMEOUT_W)
   ) u_watchdog (
      .clk     (clk),
      .rstn    (rstn),
      .run     (in_stage),
      .restart (first_cycle),
      .expired (wd_expired)
   );

   assign fault = fault_q;
`else
   assign fault = 1'b0;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= StIdle;
         pulse_q     <= 4'b0000;
         mask_q      <= 4'b0000;
         err_count_q <= 3'd0;
         busy_q      <= 1'b0;
         run_done_q  <= 1'b0;
`ifdef BCH_SEQ_TIMEOUT_EN
         fault_q       <= 1'b0;
         fault_stage_q <= StIdle;
`endif
      end else begin
         pulse_q <= 4'b0000;
         if (abort) begin
            state_q    <= StIdle;
            busy_q     <= 1'b0;
            run_done_q <= 1'b0;
`ifdef BCH_SEQ_TIMEOUT_EN
            fault_q    <= 1'b0;
`endif
         end else begin
            case (state_q)
               StIdle, StFinished, StFault: begin
                  if (start) begin
                     mask_q      <= start_mask;
                     err_count_q <= num_clamped;
                     state_q     <= start_next;
                     pulse_q     <= stage_mask(start_next);
                     busy_q      <= (start_next != StFinished);
                     run_done_q  <= (start_next == StFinished);
`ifdef BCH_SEQ_TIMEOUT_EN
                     fault_q     <= 1'b0;
`endif
                  end
               end
               StEncode, StNoise, StErrgen, StDecode: begin
                  if (stage_done) begin
                     state_q    <= adv_next;
                     pulse_q    <= stage_mask(adv_next);
                     busy_q     <= (adv_next != StFinished);
                     run_done_q <= (adv_next == StFinished);
                  end
`ifdef BCH_SEQ_TIMEOUT_EN
                  else if (wd_expired) begin
                     state_q       <= StFault;
                     busy_q        <= 1'b0;
                     fault_q       <= 1'b1;
                     fault_stage_q <= state_q;
                  end
`endif
               end
               default: begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign enc_start   = pulse_q[0];
   assign noise_start = pulse_q[1];
   assign err_start   = pulse_q[2];
   assign dec_start   = pulse_q[3];
   assign err_count   = err_count_q;
   assign busy        = busy_q;
   assign run_done    = run_done_q;
   assign state_o     = state_q;

endmodule

// File: tb/tb_bch_stage_sequencer.sv
// Directed plus randomized bench for bch_stage_sequencer against a stage-list model.
// Define BCH_SEQ_TIMEOUT_EN to exercise the watchdog path (TIMEOUT_W=4).
module tb_bch_stage_sequencer;

   logic       clk = 1'b0;
   logic       rstn;
   logic       start;
   logic       abort;
   logic       e;
   logic       n;
   logic       r;
   logic [7:0] num;
   logic [3:0] dn;
   logic       enc_s;
   logic       noise_s;
   logic       err_s;
   logic       dec_s;
   logic [2:0] err_count;
   logic [2:0] state_o;
   logic       busy;
   logic       run_done;
   logic       fault;

   int vectors = 0;
   int errs    = 0;

   always #5 clk = ~clk;

   bch_stage_sequencer #(
      .MAX_ERRORS (4),
      .TIMEOUT_W  (4)
   ) dut (
      .clk          (clk),
      .rstn         (rstn),
      .start        (start),
      .abort        (abort),
      .cfg_enc_en   (e),
      .cfg_noise_en (n),
      .cfg_err_en   (r),
      .cfg_num_err  (num),
      .enc_start    (enc_s),
      .noise_start  (noise_s),
      .err_start    (err_s),
      .dec_start    (dec_s),
      .enc_done     (dn[0]),
      .noise_done   (dn[1]),
      .err_done     (dn[2]),
      .dec_done     (dn[3]),
      .err_count    (err_count),
      .busy         (busy),
      .run_done     (run_done),
      .fault        (fault),
      .state_o      (state_o)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] pulse_vec();
      return {dec_s, err_s, noise_s, enc_s};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Model: the expected stage list follows directly from the enables; dly=0 randomizes timing.
   task automatic run_cfg(input bit ce, input bit cn, input bit cr, input logic [7:0] cnum,
                          input int dly);
      int         q[$];
      int         exp_cnt;
      int         d;
      logic [3:0] own;
      if (ce) q.push_back(1);
      if (cn) q.push_back(2);
      if (cr && cnum != 8'd0) q.push_back(3);
      if (ce) q.push_back(4);
      exp_cnt = (cnum > 8'd4) ? 4 : int'(cnum);
      e = ce; n = cn; r = cr; num = cnum; start = 1'b1;
      tick;
      start = 1'b0;
      e = 1'($urandom); n = 1'($urandom); r = 1'($urandom); num = 8'($urandom);
      foreach (q[i]) begin
         own = 4'(32'd1 << (q[i] - 1));
         chk("stage_state", state_o, q[i]);
         chk("stage_pulse", pulse_vec(), own);
         chk("busy_in_stage", busy, 1);
         chk("err_count", err_count, exp_cnt);
         d  = (dly > 0) ? dly : $urandom_range(1, 6);
         dn = (dly > 0) ? 4'b0000 : 4'($urandom);
         tick;
         chk("pulse_width", pulse_vec(), 0);
         for (int k = 1; k < d; k++) begin
            dn = 4'($urandom) & ~own;
            chk("hold_state", state_o, q[i]);
            tick;
         end
         dn = (dly > 0) ? own : (own | 4'($urandom));
         tick;
         dn = 4'b0000;
      end
      chk("finish_state", state_o, 5);
      chk("finish_run_done", run_done, 1);
      chk("finish_busy", busy, 0);
      chk("finish_pulses", pulse_vec(), 0);
      chk("finish_fault", fault, 0);
   endtask

   initial begin
      rstn = 1'b0; start = 1'b0; abort = 1'b0;
      e = 1'b0; n = 1'b0; r = 1'b0; num = 8'd0; dn = 4'b0000;
      #12;
      chk("rst_state", state_o, 0);
      chk("rst_pulses", pulse_vec(), 0);
      chk("rst_busy", busy, 0);
      chk("rst_run_done", run_done, 0);
      chk("rst_fault", fault, 0);
      chk("rst_err_count", err_count, 0);
      rstn = 1'b1;
      tick;

      run_cfg(1'b1, 1'b1, 1'b1, 8'd3, 5);
      run_cfg(1'b0, 1'b1, 1'b0, 8'd2, 3);
      run_cfg(1'b1, 1'b1, 1'b1, 8'd9, 2);
      run_cfg(1'b1, 1'b1, 1'b1, 8'd0, 2);
      run_cfg(1'b0, 1'b0, 1'b0, 8'd5, 1);

      // Stale done on the pulse cycle and a start while busy are both ignored.
      e = 1'b1; n = 1'b1; r = 1'b1; num = 8'd2; start = 1'b1;
      tick;
      start = 1'b0; dn = 4'b0001;
      tick;
      dn = 4'b0000;
      chk("stale_done_state", state_o, 1);
      chk("stale_done_pulses", pulse_vec(), 0);
      e = 1'b0; num = 8'd1; start = 1'b1;
      tick;
      start = 1'b0;
      chk("busy_start_state", state_o, 1);
      chk("busy_start_err_count", err_count, 2);
      dn = 4'b0001;
      tick;
      dn = 4'b0000;
      chk("after_enc_state", state_o, 2);
      chk("after_enc_pulse", pulse_vec(), 4'b0010);
      abort = 1'b1;
      tick;
      abort = 1'b0;
      chk("abort_idle", state_o, 0);

      // Abort wins over a simultaneous done and start.
      e = 1'b1; n = 1'b1; r = 1'b1; num = 8'd3; start = 1'b1;
      tick;
      start = 1'b0;
      tick;
      dn = 4'b0001; abort = 1'b1; start = 1'b1;
      tick;
      dn = 4'b0000; abort = 1'b0; start = 1'b0;
      chk("abort_state", state_o, 0);
      chk("abort_pulses", pulse_vec(), 0);
      chk("abort_busy", busy, 0);
      chk("abort_cfg_kept", err_count, 3);
      tick;
      chk("abort_no_noise", pulse_vec(), 0);
      run_cfg(1'b1, 1'b1, 1'b1, 8'd3, 4);

      // Asynchronous reset mid-run.
      e = 1'b1; n = 1'b0; r = 1'b1; num = 8'd4; start = 1'b1;
      tick;
      start = 1'b0;
      tick;
      #2 rstn = 1'b0;
      #1;
      chk("midrst_state", state_o, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_err_count", err_count, 0);
      chk("midrst_pulses", pulse_vec(), 0);
      rstn = 1'b1;
      tick;

      for (int i = 0; i < 20; i++) begin
         run_cfg(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom_range(0, 9)), 0);
      end

      e = 1'b0; n = 1'b1; r = 1'b0; num = 8'd0; start = 1'b1;
      tick;
      start = 1'b0;
`ifdef BCH_SEQ_TIMEOUT_EN
      repeat (14) tick;
      chk("wd_before_expiry", state_o, 2);
      tick;
      chk("wd_fault_state", state_o, 6);
      chk("wd_fault", fault, 1);
      chk("wd_busy", busy, 0);
      run_cfg(1'b1, 1'b0, 1'b0, 8'd0, 2);
`else
      repeat (40) tick;
      chk("nowd_state", state_o, 2);
      chk("nowd_fault", fault, 0);
      chk("nowd_busy", busy, 1);
      abort = 1'b1;
      tick;
      abort = 1'b0;
      chk("nowd_abort", state_o, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
